fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of the synchronous FIFO. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO's write enable and write data. It never writes while the FIFO reports full. It sits directly in front of the FIFO in the producer-side datapath.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 8, data width; matches the FIFO data_in width
- MAX_BURST, 4, maximum consecutive beats per grant (≥1)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer valid; bit i belongs to producer i
- req_data  in  NUM_REQ*DATA_W  producer i's data in bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-producer ready; at most one bit high
- fifo_full  in  1  full flag from the FIFO
- fifo_we  out  1  FIFO write enable
- fifo_wdata  out  DATA_W  FIFO write data
- grant_valid  out  1  high while in GRANT state
- grant_id  out  clog2(NUM_REQ)  index of the current or most recent grantee
- wr_count  out  16  total accepted beats; wraps modulo 2^16

## Operation
- Transfer on producer i: req_valid[i] && req_ready[i] at a rising edge. This produces fifo_we=1 in the same cycle.
- Producer rules: once req_valid[i] is asserted, it is held and req_data is kept stable until the transfer. The only exception is that a producer may deassert valid while it is not granted.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - All req_ready are 0 and fifo_we is 0.
  - If any req_valid bit is set, the winner is the first set index starting at rr_ptr and searching upward, wrapping modulo NUM_REQ.
  - On the next edge: grant_id <= winner, beat_cnt <= 0, state <= GRANT.
- GRANT (grantee g = grant_id):
  - Combinational outputs:
    - req_ready[g] = !fifo_full
    - req_ready[j≠g] = 0
    - fifo_we = req_valid[g] && !fifo_full
    - fifo_wdata = req_data slice g
    - fifo_wdata is also driven with slice g in IDLE, but is ignored there.
  - On a transfer: beat_cnt increments and wr_count increments.
  - Release when either of these holds:
    - (a) a transfer occurs with beat_cnt == MAX_BURST-1;
    - (b) req_valid[g] == 0, in which case there is no transfer that cycle.
  - On release: state <= IDLE and rr_ptr <= (g+1) mod NUM_REQ.
  - fifo_full high while req_valid[g] is high: stall. beat_cnt holds and there is no release; the grant persists indefinitely.
- Widths:
  - beat_cnt is clog2(MAX_BURST)+1 bits.
  - rr_ptr and grant_id are clog2(NUM_REQ) bits, wrapping explicitly modulo NUM_REQ, which is correct for non-power-of-2 values.
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, wr_count=0.
  - Consequently grant_valid=0, req_ready=0, fifo_we=0.
  - Reset mid-burst abandons the burst. No further writes occur; beats already written stay in the FIFO.
  - The FIFO is reset by the same rst domain.

## Timing
- Arbitration latency: req_valid sampled high in IDLE at edge k → GRANT from edge k. The first transfer occurs at edge k+1 if not full.
- Back-to-back beats within a grant carry no bubble: one beat per cycle.
- Every release costs exactly one IDLE cycle. Full-rate throughput for a single producer is MAX_BURST/(MAX_BURST+1).
- req_ready and fifo_we are combinational from fifo_full, req_valid and registered state. There is no combinational path from req_data to control.
- fifo_we is never high in a cycle where fifo_full is high.
- grant_valid, grant_id and wr_count are registered. wr_count reflects a transfer one cycle after its edge.
- rst dominates all other inputs in the same cycle.

## Test plan
- Reset then single producer:
  - Stimulus: rst for 2 cycles, then producer 0 valid continuously with data 0x10..0x17, MAX_BURST=4.
  - Writes: 0x10–0x13 on 4 consecutive cycles, then 1 IDLE cycle, then 0x14–0x17.
  - Counters: wr_count=8 afterwards; grant_id stays 0.
- All four producers valid continuously:
  - grant_id sequence is 0,1,2,3,0. Each grant gives 4 beats, separated by one IDLE cycle.
  - rr_ptr wraps from 3 to 0.
- Full stall:
  - Stimulus: producer 2 granted, fifo_full forced high after beat 1 for 5 cycles.
  - While full: req_ready[2]=0, fifo_we=0, beat_cnt holds at 1, grant_valid stays 1.
  - After fifo_full drops: the remaining 3 beats complete, then release.
- Early drop:
  - Stimulus: producer 1 granted, deasserts valid after 2 beats, with producer 3 valid.
  - Release occurs with 2 beats written; rr_ptr=2; after one IDLE cycle, producer 3 is granted.
- Reset mid-burst:
  - Stimulus: rst asserted after beat 2 of a grant.
  - Next cycle: fifo_we=0, grant_valid=0, wr_count=0, rr_ptr=0.
  - With producers 1 and 0 valid, producer 0 is granted first.
- Non-power-of-2 configuration:
  - Stimulus: NUM_REQ=3, MAX_BURST=1, all producers valid.
  - Grants alternate 0,1,2,0,1,2 with one beat each and one IDLE cycle between grants.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers, granting bursts of up to MAX_BURST beats.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic [15:0]               wr_count
);

  localparam int unsigned BC_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]     wr_count_q, wr_count_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            release_grant;

  logic [DATA_W-1:0] slice [NUM_REQ];

  // Unpack the flat producer data bus into per-producer words.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid index at or above rr_ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    wr_count_d    = wr_count_q;
    req_ready     = '0;
    fifo_we       = 1'b0;
    fifo_wdata    = slice[grant_id_q];
    release_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_id_d = win_id;
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        req_ready[grant_id_q] = !fifo_full;
        fifo_we               = req_valid[grant_id_q] && !fifo_full;
        if (fifo_we) begin
          wr_count_d = wr_count_q + 16'd1;
          beat_cnt_d = beat_cnt_q + BC_W'(1);
          if (beat_cnt_q == BC_W'(MAX_BURST - 1)) begin
            release_grant = 1'b1;
          end
        end else if (!req_valid[grant_id_q]) begin
          release_grant = 1'b1;
        end
        // A full FIFO with a valid grantee just stalls; the grant is kept.
        if (release_grant) begin
          state_d  = S_IDLE;
          rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign grant_valid = (state_q == S_GRANT);
  assign grant_id    = grant_id_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a 4-producer/4-beat instance and a
// 3-producer/1-beat instance, sharing clock and reset.
module tb_fifo_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: NUM_REQ=4, DATA_W=8, MAX_BURST=4
  logic [3:0]  va, ra;
  logic [31:0] da;
  logic        full_a, we_a, gv_a;
  logic [7:0]  wd_a;
  logic [1:0]  gid_a;
  logic [15:0] wc_a;

  // Instance B: NUM_REQ=3, DATA_W=8, MAX_BURST=1
  logic [2:0]  vb, rb;
  logic [23:0] db;
  logic        full_b, we_b, gv_b;
  logic [7:0]  wd_b;
  logic [1:0]  gid_b;
  logic [15:0] wc_b;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(va), .req_data(da), .req_ready(ra),
    .fifo_full(full_a), .fifo_we(we_a), .fifo_wdata(wd_a),
    .grant_valid(gv_a), .grant_id(gid_a), .wr_count(wc_a)
  );

  fifo_write_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(1)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(vb), .req_data(db), .req_ready(rb),
    .fifo_full(full_b), .fifo_we(we_b), .fifo_wdata(wd_b),
    .grant_valid(gv_b), .grant_id(gid_b), .wr_count(wc_b)
  );

  // Staged inputs, applied at the next falling edge by step().
  logic       n_rst, n_full;
  logic [3:0] n_va;
  logic [2:0] n_vb;
  logic [7:0] cur_a [4];
  logic [7:0] cur_b [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: apply staged inputs on the falling edge, settle, then advance
  // each producer's data when its handshake will complete at the next rise.
  task automatic step();
    @(negedge clk);
    rst    = n_rst;
    full_a = n_full;
    va     = n_va;
    vb     = n_vb;
    for (int i = 0; i < 4; i++) da[i*8 +: 8] = cur_a[i];
    for (int i = 0; i < 3; i++) db[i*8 +: 8] = cur_b[i];
    #1;
    for (int i = 0; i < 4; i++) if (va[i] && ra[i]) cur_a[i] = cur_a[i] + 8'd1;
    for (int i = 0; i < 3; i++) if (vb[i] && rb[i]) cur_b[i] = cur_b[i] + 8'd1;
  endtask

  task automatic do_reset();
    n_va = '0; n_vb = '0; n_full = 1'b0;
    n_rst = 1'b1; step();
    n_rst = 1'b0; step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; va = '0; vb = '0; da = '0; db = '0; full_a = 1'b0; full_b = 1'b0;
    n_rst = 1'b1; n_va = '0; n_vb = '0; n_full = 1'b0;
    for (int i = 0; i < 4; i++) cur_a[i] = 8'h00;
    for (int i = 0; i < 3; i++) cur_b[i] = 8'h00;

    // Reset for two cycles, then check reset state
    step(); step();
    n_rst = 1'b0; step();
    chk("rst_gv",    32'(gv_a),  32'd0);
    chk("rst_we",    32'(we_a),  32'd0);
    chk("rst_ready", 32'(ra),    32'd0);
    chk("rst_wc",    32'(wc_a),  32'd0);
    chk("rst_gid",   32'(gid_a), 32'd0);
    chk("rst_gv_b",  32'(gv_b),  32'd0);

    // Single producer, data 0x10..0x17: 4 beats, 1 idle, 4 beats
    cur_a[0] = 8'h10;
    n_va = 4'b0001;
    begin
      logic [7:0] e_data;
      e_data = 8'h10;
      for (int c = 0; c < 10; c++) begin
        logic exp_we;
        exp_we = (c != 0) && (c != 5);
        step();
        chk("s1_we", 32'(we_a), 32'(exp_we));
        if (exp_we) begin
          chk("s1_data", 32'(wd_a),  32'(e_data));
          chk("s1_gid",  32'(gid_a), 32'd0);
          e_data = e_data + 8'd1;
        end
      end
    end
    n_va = '0; step();
    chk("s1_wc",  32'(wc_a), 32'd8);
    chk("s1_gv",  32'(gv_a), 32'd0);
    chk("s1_rr",  32'(u_dut.rr_ptr_q), 32'd1);

    // All four producers valid: grants 0,1,2,3,0, 4 beats each
    do_reset();
    for (int i = 0; i < 4; i++) cur_a[i] = 8'(8'h20 + 8'h10 * i);
    n_va = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("s2_idle_we", 32'(we_a), 32'd0);
      chk("s2_idle_gv", 32'(gv_a), 32'd0);
      chk("s2_idle_rdy", 32'(ra), 32'd0);
      for (int b = 0; b < 4; b++) begin
        step();
        chk("s2_we",   32'(we_a),  32'd1);
        chk("s2_gid",  32'(gid_a), 32'(n % 4));
        chk("s2_data", 32'(wd_a),  32'(8'h20 + 8'h10 * (n % 4) + 4 * (n / 4) + b));
      end
    end
    n_va = '0; step();
    chk("s2_wc", 32'(wc_a), 32'd20);
    chk("s2_rr", 32'(u_dut.rr_ptr_q), 32'd1);

    // Full stall on producer 2 after beat 1
    do_reset();
    cur_a[2] = 8'h40;
    n_va = 4'b0100;
    step();
    chk("s3_idle_we", 32'(we_a), 32'd0);
    step();
    chk("s3_b0_we",   32'(we_a),  32'd1);
    chk("s3_b0_gid",  32'(gid_a), 32'd2);
    chk("s3_b0_data", 32'(wd_a),  32'h40);
    n_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("s3_stall_rdy", 32'(ra),   32'd0);
      chk("s3_stall_we",  32'(we_a), 32'd0);
      chk("s3_stall_gv",  32'(gv_a), 32'd1);
      chk("s3_stall_bc",  32'(u_dut.beat_cnt_q), 32'd1);
    end
    n_full = 1'b0;
    for (int b = 1; b < 4; b++) begin
      step();
      chk("s3_we",   32'(we_a), 32'd1);
      chk("s3_rdy",  32'(ra),   32'b0100);
      chk("s3_data", 32'(wd_a), 32'(8'h40 + b));
    end
    n_va = '0; step();
    chk("s3_rel_gv", 32'(gv_a), 32'd0);
    chk("s3_wc",     32'(wc_a), 32'd4);

    // Early drop: producer 1 leaves after 2 beats, producer 3 waiting
    do_reset();
    cur_a[1] = 8'h50; cur_a[3] = 8'h70;
    n_va = 4'b1010;
    step();
    chk("s4_idle_we", 32'(we_a), 32'd0);
    step();
    chk("s4_b0_gid",  32'(gid_a), 32'd1);
    chk("s4_b0_data", 32'(wd_a),  32'h50);
    step();
    chk("s4_b1_data", 32'(wd_a),  32'h51);
    n_va = 4'b1000;
    step();
    chk("s4_drop_we", 32'(we_a), 32'd0);
    chk("s4_drop_gv", 32'(gv_a), 32'd1);
    step();
    chk("s4_idle_gv", 32'(gv_a), 32'd0);
    chk("s4_rr",      32'(u_dut.rr_ptr_q), 32'd2);
    chk("s4_wc",      32'(wc_a), 32'd2);
    step();
    chk("s4_p3_we",   32'(we_a),  32'd1);
    chk("s4_p3_gid",  32'(gid_a), 32'd3);
    chk("s4_p3_data", 32'(wd_a),  32'h70);
    n_va = '0; step(); step();

    // Reset mid-burst after beat 2
    do_reset();
    cur_a[0] = 8'h80;
    n_va = 4'b0001;
    step();
    step();
    chk("s5_b0_data", 32'(wd_a), 32'h80);
    step();
    chk("s5_b1_data", 32'(wd_a), 32'h81);
    n_rst = 1'b1; n_va = 4'b0011;
    step();
    n_rst = 1'b0;
    step();
    chk("s5_we", 32'(we_a), 32'd0);
    chk("s5_gv", 32'(gv_a), 32'd0);
    chk("s5_wc", 32'(wc_a), 32'd0);
    chk("s5_rr", 32'(u_dut.rr_ptr_q), 32'd0);
    step();
    chk("s5_gv2",  32'(gv_a),  32'd1);
    chk("s5_gid2", 32'(gid_a), 32'd0);
    chk("s5_we2",  32'(we_a),  32'd1);
    n_va = '0; step(); step();

    // NUM_REQ=3, MAX_BURST=1: grants 0,1,2,0,1,2, single beats
    do_reset();
    for (int i = 0; i < 3; i++) cur_b[i] = 8'(8'h90 + 8'h10 * i);
    n_vb = 3'b111;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("s6_idle_we", 32'(we_b), 32'd0);
      chk("s6_idle_gv", 32'(gv_b), 32'd0);
      step();
      chk("s6_we",   32'(we_b),  32'd1);
      chk("s6_gid",  32'(gid_b), 32'(n % 3));
      chk("s6_data", 32'(wd_b),  32'(8'h90 + 8'h10 * (n % 3) + n / 3));
    end
    n_vb = '0; step();
    chk("s6_wc", 32'(wc_b), 32'd6);
    chk("s6_gv", 32'(gv_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
